// File: rtl/tdm_demux.sv
// tdm_demux: receive side of the N:1 time-division serial path.
// Each valid beat carries one slot bit; slot 0 is flagged by sync. Beats are
// collected into a shadow register and the finished frame is published on out
// with a one-cycle out_valid strobe. Alignment faults pulse sync_err.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   din        serial data bit for the current slot
//   din_valid  din/sync valid this cycle (one beat)
//   sync       beat is slot 0 of a frame
//   out        last completed frame, bit k = slot k (registered)
//   out_valid  one-cycle pulse when out has just been updated
//   sel        slot index the next beat will be written to (registered)
//   sync_err   one-cycle pulse on an alignment violation
module tdm_demux #(
    parameter int unsigned N     = 8,
    parameter int unsigned SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sync,
    output logic [N-1:0]     out,
    output logic             out_valid,
    output logic [SEL_W-1:0] sel,
    output logic             sync_err
);

    localparam int unsigned SH_W = N - 1;
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N - 1);
    localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_n;
    // Slot N-1 goes straight from din into out, so only N-1 bits are buffered.
    logic [SH_W-1:0]  r_shadow;
    logic [SH_W-1:0]  w_shadow_n;
    logic [SEL_W-1:0] w_sel_n;
    logic [N-1:0]     w_out_n;
    logic             w_out_valid_n;
    logic             w_sync_err_n;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= HUNT;
            r_shadow  <= '0;
            sel       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_shadow  <= w_shadow_n;
            sel       <= w_sel_n;
            out       <= w_out_n;
            out_valid <= w_out_valid_n;
            sync_err  <= w_sync_err_n;
        end
    end

    // Next-state and next-output logic; everything holds without a beat.
    always_comb begin
        w_state_n     = r_state;
        w_shadow_n    = r_shadow;
        w_sel_n       = sel;
        w_out_n       = out;
        w_out_valid_n = 1'b0;
        w_sync_err_n  = 1'b0;

        if (din_valid) begin
            case (r_state)
                HUNT: begin
                    // Unsynced beats are discarded silently while hunting.
                    if (sync) begin
                        w_shadow_n[0] = din;
                        w_sel_n       = SEL_ONE;
                        w_state_n     = RECV;
                    end
                end
                RECV: begin
                    if (sel == '0) begin
                        if (sync) begin
                            w_shadow_n[0] = din;
                            w_sel_n       = SEL_ONE;
                        end else begin
                            // Expected a frame start but got none: lose lock.
                            w_sync_err_n = 1'b1;
                            w_sel_n      = '0;
                            w_state_n    = HUNT;
                        end
                    end else if (sync) begin
                        // Early sync: drop the partial frame, restart at slot 0.
                        w_sync_err_n  = 1'b1;
                        w_shadow_n[0] = din;
                        w_sel_n       = SEL_ONE;
                    end else if (sel == SEL_LAST) begin
                        w_out_n       = {din, r_shadow};
                        w_out_valid_n = 1'b1;
                        w_sel_n       = '0;
                    end else begin
                        w_shadow_n[sel] = din;
                        w_sel_n         = sel + SEL_ONE;
                    end
                end
                default: begin
                    w_state_n = HUNT;
                    w_sel_n   = '0;
                end
            endcase
        end
    end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Sequential 1-to-N time-division demultiplexer and deserializer; the receiving end of the 8:1 select-mux serial path.
- A serializer drives one bit per valid beat, slot 0 first, and marks slot 0 with `sync`.
- This block steers each beat into slot `sel` of a shadow register. It presents the completed N-bit frame on `out` with a one-cycle `out_valid` strobe.
- Frame alignment is checked on every beat. Misalignment is flagged on `sync_err`.

Parameters:
- N, 8, number of channels/slots per frame (power of two, ≥2).
- SEL_W, 3, slot index width; equals log2(N).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- din  input  1  serial data bit for the current slot.
- din_valid  input  1  `din` and `sync` are valid this cycle (a "beat").
- sync  input  1  current beat is slot 0 of a frame; ignored when `din_valid`=0.
- out  output  N  last completed frame; bit k = slot k; registered.
- out_valid  output  1  one-cycle pulse when `out` has just been updated.
- sel  output  SEL_W  slot index the next beat will be written to; registered.
- sync_err  output  1  one-cycle pulse on an alignment violation.

Behaviour:
- Reset (`rst_n`=0 at a clk edge), applied in any state including mid-frame:
  - `out`=0, `out_valid`=0, `sel`=0, `sync_err`=0, shadow=0, state=HUNT.
  - Any partial frame is discarded.
- States are HUNT (unaligned) and RECV (aligned). No beat is consumed when `din_valid`=0. All state, `sel` and shadow values hold when `din_valid`=0.
- HUNT:
  - Beat with `sync`=0: dropped, no error.
  - Beat with `sync`=1: shadow[0]<=`din`, `sel`<=1, go to RECV.
- RECV, beat with `sync`=0 and `sel`≠0: shadow[`sel`]<=`din`, `sel`<=`sel`+1.
- RECV, beat with `sel`=N-1 and `sync`=0 (frame complete):
  - `out`<={`din`, shadow[N-2:0]}.
  - `out_valid`=1 in the following cycle only.
  - `sel` wraps to 0; stay in RECV.
- RECV, beat with `sync`=1 and `sel`≠0 (early sync):
  - `sync_err`=1 next cycle.
  - Partial frame abandoned; `out` unchanged.
  - Beat is taken as slot 0 of a new frame: shadow[0]<=`din`, `sel`<=1.
- RECV, beat with `sel`=0:
  - `sync`=1: normal slot 0 (shadow[0]<=`din`, `sel`<=1).
  - `sync`=0 (missing sync): `sync_err`=1 next cycle, beat dropped, go to HUNT, `sel`=0.
- Shadow bits for slots ≥ `sel` are not cleared at a frame start; each is overwritten before use.
- Latency: `out` and `out_valid` appear 1 cycle after the edge accepting the slot N-1 beat.
  - Back-to-back frames at full rate give one `out_valid` every N cycles.
- `out` holds its value between frames. `out_valid` and `sync_err` are never asserted together.
- Wrap-around: `sel` arithmetic is modulo N.
  - Only the explicit `sel`=N-1 completion path produces a frame.
  - `sel`=0 is only reached by completion, missing-sync handling or reset.

Test Plan:
- Reset then frame 8'b10101010:
  - Stimulus: `din` = 0,1,0,1,0,1,0,1 (slots 0..7), `sync`=1 on the first beat only, `din_valid`=1 continuously.
  - Required: `out`=8'hAA with `out_valid`=1 exactly once, 1 cycle after the 8th beat; `sel` steps 0..7 then back to 0.
- Gapped valid: same frame with `din_valid`=0 for 3 cycles between slots 3 and 4.
  - Required: `out`=8'hAA; `sel` holds at 4 during the gap; `out_valid` is delayed by 3 cycles.
- HUNT drop:
  - Stimulus: 5 beats with `sync`=0 after reset, then a synced frame of 8'h3C (bits 0,0,1,1,1,1,0,0).
  - Required: no `out_valid` and no `sync_err` during the 5 beats; `out`=8'h3C afterwards.
- Early sync:
  - Stimulus: `sync`=1 asserted at slot 5 of frame 8'hAA, followed by a full frame 8'hF0.
  - Required: `sync_err` pulses once; `out` stays at its old value; then `out`=8'hF0 with a single `out_valid`.
- Missing sync:
  - Stimulus: after frame 8'h55, next beat at `sel`=0 arrives with `sync`=0.
  - Required: `sync_err` pulses once and state returns to HUNT; a later synced frame 8'h81 gives `out`=8'h81.
- Reset mid-frame:
  - Stimulus: `rst_n`=0 for 1 cycle after slot 4.
  - Required: the next cycle shows `out`=0, `sel`=0, no `out_valid`; remaining beats without `sync` are dropped.
